half_adder: RTL and testbench



---
 rtl/half_adder_pkg.sv | 8 +
 rtl/half_adder_cell.sv | 12 +
 rtl/half_adder.sv | 72 +++++++
 tb/tb_half_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants for the half-adder array: the default counter width and
// its saturation value.
package half_adder_pkg;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// One-bit combinational half-adder cell: sum = a ^ b, carry = a & b.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Bit-parallel half-adder array with a combinational result, a registered
// valid-qualified copy, and a saturating carry-event counter.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic [WIDTH-1:0] res_carry_q, res_carry_d;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    cnt_d       = cnt_q;
    if (in_valid) begin
      res_sum_d   = sum;
      res_carry_d = carry;
      if (|carry && cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q   <= '0;
      res_carry_q <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      valid_q     <= in_valid;
      cnt_q       <= cnt_d;
    end
  end

  assign sum_q     = res_sum_q;
  assign carry_q   = res_carry_q;
  assign out_valid = valid_q;
  assign carry_cnt = cnt_q;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: three instances (1-lane, 8-lane, 1-lane
// with a 2-bit counter) share clock and reset.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=1, CNT_W=16
  logic        v0 = 1'b0;
  logic [0:0]  a0 = '0, b0 = '0;
  logic [0:0]  s0, c0, sq0, cq0;
  logic        ov0;
  logic [15:0] cnt0;
  // Instance 1: WIDTH=8, CNT_W=16
  logic        v1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic [7:0]  s1, c1, sq1, cq1;
  logic        ov1;
  logic [15:0] cnt1;
  // Instance 2: WIDTH=1, CNT_W=2
  logic        v2 = 1'b0;
  logic [0:0]  a2 = '0, b2 = '0;
  logic [0:0]  s2, c2, sq2, cq2;
  logic        ov2;
  logic [1:0]  cnt2;

  half_adder #(.WIDTH(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .a(a0), .b(b0),
    .sum(s0), .carry(c0), .out_valid(ov0), .sum_q(sq0), .carry_q(cq0), .carry_cnt(cnt0));
  half_adder #(.WIDTH(8), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .sum(s1), .carry(c1), .out_valid(ov1), .sum_q(sq1), .carry_q(cq1), .carry_cnt(cnt1));
  half_adder #(.WIDTH(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2),
    .sum(s2), .carry(c2), .out_valid(ov2), .sum_q(sq2), .carry_q(cq2), .carry_cnt(cnt2));

  typedef struct {
    int          id;
    logic [7:0]  s;
    logic [7:0]  c;
    logic        v;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state per instance
  logic [7:0]  m_sum   [3];
  logic [7:0]  m_carry [3];
  logic [15:0] m_cnt   [3];
  int          lane_w  [3] = '{1, 8, 1};
  int          cnt_w   [3] = '{16, 16, 2};

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lane_mask(input int id);
    return (lane_w[id] == 8) ? 8'hFF : 8'h01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = '0; m_carry[i] = '0; m_cnt[i] = '0;
    end
  endtask

  task automatic get_reg(input int id, output logic [7:0] s, output logic [7:0] c,
                         output logic v, output logic [15:0] cnt);
    case (id)
      0: begin s = {7'd0, sq0}; c = {7'd0, cq0}; v = ov0; cnt = cnt0; end
      1: begin s = sq1; c = cq1; v = ov1; cnt = cnt1; end
      default: begin s = {7'd0, sq2}; c = {7'd0, cq2}; v = ov2; cnt = {14'd0, cnt2}; end
    endcase
  endtask

  task automatic check_comb(input string tag, input int id, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s, c, m;
    m = lane_mask(id);
    case (id)
      0: begin s = {7'd0, s0}; c = {7'd0, c0}; end
      1: begin s = s1; c = c1; end
      default: begin s = {7'd0, s2}; c = {7'd0, c2}; end
    endcase
    check({tag, ".sum"},   {24'd0, s}, {24'd0, (a ^ b) & m});
    check({tag, ".carry"}, {24'd0, c}, {24'd0, (a & b) & m});
  endtask

  // Drive one cycle on instance id at the falling edge, check the combinational
  // result, push the model's registered expectation, then compare after the edge.
  task automatic step(input string tag, input int id, input logic [7:0] a,
                      input logic [7:0] b, input logic v);
    exp_t e;
    logic [7:0] m, es, ec;
    logic [7:0] gs, gc;
    logic gv;
    logic [15:0] gcnt, max;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    case (id)
      0: begin a0 = a[0:0]; b0 = b[0:0]; v0 = v; end
      1: begin a1 = a; b1 = b; v1 = v; end
      default: begin a2 = a[0:0]; b2 = b[0:0]; v2 = v; end
    endcase
    #1;
    check_comb(tag, id, a, b);
    m  = lane_mask(id);
    es = (a ^ b) & m;
    ec = (a & b) & m;
    max = 16'((32'd1 << cnt_w[id]) - 1);
    if (v) begin
      m_sum[id]   = es;
      m_carry[id] = ec;
      if (ec != 8'd0 && m_cnt[id] != max) m_cnt[id] = m_cnt[id] + 16'd1;
    end
    e.id = id; e.s = m_sum[id]; e.c = m_carry[id]; e.v = v; e.cnt = m_cnt[id];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      get_reg(e.id, gs, gc, gv, gcnt);
      check({tag, ".sum_q"},     {24'd0, gs}, {24'd0, e.s});
      check({tag, ".carry_q"},   {24'd0, gc}, {24'd0, e.c});
      check({tag, ".out_valid"}, {31'd0, gv}, {31'd0, e.v});
      check({tag, ".carry_cnt"}, {16'd0, gcnt}, {16'd0, e.cnt});
    end
  endtask

  initial begin
    logic [7:0] gs, gc;
    logic gv;
    logic [15:0] gcnt;
    model_reset();

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      get_reg(i, gs, gc, gv, gcnt);
      check($sformatf("rst%0d.regs", i), {gs, gc, 15'd0, gv}, 32'd0);
      check($sformatf("rst%0d.cnt", i), {16'd0, gcnt}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table
    step("tt00", 0, 8'd0, 8'd0, 1'b1);
    step("tt01", 0, 8'd0, 8'd1, 1'b1);
    step("tt10", 0, 8'd1, 8'd0, 1'b1);
    step("tt11", 0, 8'd1, 8'd1, 1'b1);

    // WIDTH=8 capture, then hold with in_valid=0
    step("w8cap",  1, 8'hF0, 8'h3C, 1'b1);
    step("w8hold", 1, 8'hFF, 8'hFF, 1'b0);

    // Asynchronous reset between edges while registered outputs are nonzero
    #2;
    a1 = 8'h0F; b1 = 8'h05;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      get_reg(i, gs, gc, gv, gcnt);
      check($sformatf("arst%0d.regs", i), {gs, gc, 15'd0, gv}, 32'd0);
      check($sformatf("arst%0d.cnt", i), {16'd0, gcnt}, 32'd0);
    end
    check_comb("arst.comb", 1, 8'h0F, 8'h05);
    v1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
    @(posedge clk);
    #1;
    get_reg(1, gs, gc, gv, gcnt);
    check("arst.no_capture", {gs, gc, 15'd0, gv}, 32'd0);
    check_comb("arst.comb2", 1, 8'hFF, 8'hFF);
    @(negedge clk);
    v1 = 1'b0;
    rst_n = 1'b1;
    step("post_rst", 1, 8'hAA, 8'h0F, 1'b1);

    // CNT_W=2 saturation: counter reads 1,2,3,3,3
    for (int i = 0; i < 5; i++) step($sformatf("sat%0d", i), 2, 8'd1, 8'd1, 1'b1);

    // Random traffic on the 8-lane instance
    for (int i = 0; i < 24; i++)
      step($sformatf("rnd%0d", i), 1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_half_adder
